// File: rtl/game_pkg.sv
// Shared state codes, comparator status codes and score width for the game controller.
package game_pkg;

    localparam int unsigned SCORE_W = 8;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPlay     = 3'd1,
        StCrash    = 3'd2,
        StLevelUp  = 3'd3,
        StGameOver = 3'd4,
        StVictory  = 3'd5
    } state_t;

    localparam logic [1:0] ST_CRASH = 2'b00;
    localparam logic [1:0] ST_NONE  = 2'b10;
    localparam logic [1:0] ST_GOAL  = 2'b11;

endpackage

// File: rtl/sc_hold_timer.sv
// Dwell timer: load arms it for HOLD_CYCLES cycles, expire flags the last cycle of the dwell.
module sc_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CntW'(HOLD_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CntW'(1));

endmodule

// File: rtl/sc_game_state_ctrl.sv
// Game state controller: lives, levels, crash/level-up dwell and optional score.
// Score logic exists only when SC_GAME_STATE_CTRL_SCORE_EN is defined.
module sc_game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned LEVELS      = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic               SC_GAME_STATE_CTRL_CLOCK_50,
    input  logic               SC_GAME_STATE_CTRL_RESET_InLow,
    input  logic [1:0]         SC_GAME_STATE_CTRL_status_InBUS,
    input  logic               SC_GAME_STATE_CTRL_statusValid_In,
    input  logic               SC_GAME_STATE_CTRL_start_In,
    output logic [2:0]         SC_GAME_STATE_CTRL_state_OutBUS,
    output logic [2:0]         SC_GAME_STATE_CTRL_lives_OutBUS,
    output logic [2:0]         SC_GAME_STATE_CTRL_level_OutBUS,
    output logic               SC_GAME_STATE_CTRL_frogReset_Out,
    output logic               SC_GAME_STATE_CTRL_obstacleEn_Out,
    output logic [SCORE_W-1:0] SC_GAME_STATE_CTRL_score_OutBUS
);

    logic       clk;
    logic       rst_n;
    logic       play_valid;
    state_t     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [2:0] level_q, level_d;
    logic       frog_reset_q;
    logic       obstacle_en_q;
    logic       hold_load;
    logic       hold_expire;

    assign clk        = SC_GAME_STATE_CTRL_CLOCK_50;
    assign rst_n      = SC_GAME_STATE_CTRL_RESET_InLow;
    assign play_valid = (state_q == StPlay) && SC_GAME_STATE_CTRL_statusValid_In;

    sc_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (hold_load),
        .expire (hold_expire)
    );

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        hold_load = 1'b0;
        case (state_q)
            StIdle, StGameOver, StVictory: begin
                if (SC_GAME_STATE_CTRL_start_In) begin
                    state_d = StPlay;
                    lives_d = 3'(LIVES_INIT);
                    level_d = 3'd0;
                end
            end
            StPlay: begin
                if (play_valid && SC_GAME_STATE_CTRL_status_InBUS == ST_CRASH) begin
                    // <= 1 also covers a zero count so lives cannot underflow
                    if (lives_q <= 3'd1) begin
                        state_d = StGameOver;
                        lives_d = 3'd0;
                    end else begin
                        state_d   = StCrash;
                        lives_d   = lives_q - 3'd1;
                        hold_load = 1'b1;
                    end
                end else if (play_valid && SC_GAME_STATE_CTRL_status_InBUS == ST_GOAL) begin
                    if (level_q == 3'(LEVELS - 1)) begin
                        state_d = StVictory;
                    end else begin
                        state_d   = StLevelUp;
                        hold_load = 1'b1;
                    end
                end
            end
            StCrash: begin
                if (hold_expire) begin
                    state_d = StPlay;
                end
            end
            StLevelUp: begin
                if (hold_expire) begin
                    state_d = StPlay;
                    level_d = level_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            lives_q       <= 3'd0;
            level_q       <= 3'd0;
            frog_reset_q  <= 1'b0;
            obstacle_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            frog_reset_q  <= (state_d == StPlay) && (state_q != StPlay);
            obstacle_en_q <= (state_d == StPlay);
        end
    end

`ifdef SC_GAME_STATE_CTRL_SCORE_EN
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   score_sum;

    always_comb begin
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(level_q) + (SCORE_W + 1)'(1);
        score_d   = score_q;
        if ((state_q == StIdle || state_q == StGameOver || state_q == StVictory) &&
            SC_GAME_STATE_CTRL_start_In) begin
            score_d = '0;
        end else if (play_valid && SC_GAME_STATE_CTRL_status_InBUS == ST_GOAL) begin
            score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign SC_GAME_STATE_CTRL_score_OutBUS = score_q;
`else
    assign SC_GAME_STATE_CTRL_score_OutBUS = '0;
`endif

    assign SC_GAME_STATE_CTRL_state_OutBUS    = state_q;
    assign SC_GAME_STATE_CTRL_lives_OutBUS    = lives_q;
    assign SC_GAME_STATE_CTRL_level_OutBUS    = level_q;
    assign SC_GAME_STATE_CTRL_frogReset_Out   = frog_reset_q;
    assign SC_GAME_STATE_CTRL_obstacleEn_Out  = obstacle_en_q;

endmodule

// File: tb/tb_sc_game_state_ctrl.sv
// Scoreboard bench for sc_game_state_ctrl with LIVES_INIT=3, LEVELS=2, HOLD_CYCLES=4.
module tb_sc_game_state_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] status;
    logic       status_valid;
    logic       start;
    logic [2:0] state;
    logic [2:0] lives;
    logic [2:0] level;
    logic       frog_reset;
    logic       obstacle_en;
    logic [7:0] score;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic [2:0] st;
        logic [2:0] lv;
        logic [2:0] lvl;
        logic       fr;
        logic       ob;
    } exp_t;

    exp_t sb[$];

`ifdef SC_GAME_STATE_CTRL_SCORE_EN
    localparam int unsigned ScoreAfterWin = 3;
`else
    localparam int unsigned ScoreAfterWin = 0;
`endif

    sc_game_state_ctrl #(
        .LIVES_INIT  (3),
        .LEVELS      (2),
        .HOLD_CYCLES (4)
    ) dut (
        .SC_GAME_STATE_CTRL_CLOCK_50       (clk),
        .SC_GAME_STATE_CTRL_RESET_InLow    (rst_n),
        .SC_GAME_STATE_CTRL_status_InBUS   (status),
        .SC_GAME_STATE_CTRL_statusValid_In (status_valid),
        .SC_GAME_STATE_CTRL_start_In       (start),
        .SC_GAME_STATE_CTRL_state_OutBUS   (state),
        .SC_GAME_STATE_CTRL_lives_OutBUS   (lives),
        .SC_GAME_STATE_CTRL_level_OutBUS   (level),
        .SC_GAME_STATE_CTRL_frogReset_Out  (frog_reset),
        .SC_GAME_STATE_CTRL_obstacleEn_Out (obstacle_en),
        .SC_GAME_STATE_CTRL_score_OutBUS   (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag, input exp_t e);
        check({tag, ".state"}, 32'(state), 32'(e.st));
        check({tag, ".lives"}, 32'(lives), 32'(e.lv));
        check({tag, ".level"}, 32'(level), 32'(e.lvl));
        check({tag, ".frog"}, 32'(frog_reset), 32'(e.fr));
        check({tag, ".obs"}, 32'(obstacle_en), 32'(e.ob));
    endtask

    // Drive one cycle of stimulus, queue what the outputs must read after that edge.
    task automatic step(input string tag, input logic st_in, input logic [1:0] stat,
                        input logic vld, input logic [2:0] e_st, input logic [2:0] e_lv,
                        input logic [2:0] e_lvl, input logic e_fr, input logic e_ob);
        exp_t e;
        @(negedge clk);
        start        = st_in;
        status       = stat;
        status_valid = vld;
        e.st = e_st; e.lv = e_lv; e.lvl = e_lvl; e.fr = e_fr; e.ob = e_ob;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check_now(tag, e);
        end
    endtask

    task automatic idle_steps(input string tag, input int n, input logic [2:0] e_st,
                              input logic [2:0] e_lv, input logic [2:0] e_lvl);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b0, 2'b10, 1'b0, e_st, e_lv, e_lvl, 1'b0, 1'b0);
        end
    endtask

    initial begin
        exp_t z;
        n_checks = 0;
        n_fail   = 0;
        z.st = 3'd0; z.lv = 3'd0; z.lvl = 3'd0; z.fr = 1'b0; z.ob = 1'b0;
        start = 1'b0; status = 2'b10; status_valid = 1'b0;
        rst_n = 1'b0;
        #12;
        check_now("reset", z);
        check("reset.score", 32'(score), 0);
        @(negedge clk);
        rst_n = 1'b1;

        step("idle_hold", 1'b0, 2'b00, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        step("start", 1'b1, 2'b10, 1'b0, 3'd1, 3'd3, 3'd0, 1'b1, 1'b1);
        step("play", 1'b0, 2'b10, 1'b1, 3'd1, 3'd3, 3'd0, 1'b0, 1'b1);
        step("crash_novalid", 1'b0, 2'b00, 1'b0, 3'd1, 3'd3, 3'd0, 1'b0, 1'b1);
        step("crash1", 1'b0, 2'b00, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0);
        step("crash_start", 1'b1, 2'b10, 1'b0, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0);
        step("crash_stat", 1'b0, 2'b00, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0);
        step("crash_c4", 1'b1, 2'b11, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0);
        step("crash_back", 1'b0, 2'b10, 1'b0, 3'd1, 3'd2, 3'd0, 1'b1, 1'b1);
        step("play2", 1'b0, 2'b01, 1'b1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b1);

        step("goal0", 1'b0, 2'b11, 1'b1, 3'd3, 3'd2, 3'd0, 1'b0, 1'b0);
        idle_steps("lvlup", 3, 3'd3, 3'd2, 3'd0);
        step("lvlup_back", 1'b0, 2'b10, 1'b0, 3'd1, 3'd2, 3'd1, 1'b1, 1'b1);
        step("goal1", 1'b0, 2'b11, 1'b1, 3'd5, 3'd2, 3'd1, 1'b0, 1'b0);
        check("victory.score", 32'(score), ScoreAfterWin);
        step("victory_hold", 1'b0, 2'b11, 1'b1, 3'd5, 3'd2, 3'd1, 1'b0, 1'b0);

        step("restart", 1'b1, 2'b10, 1'b0, 3'd1, 3'd3, 3'd0, 1'b1, 1'b1);
        check("restart.score", 32'(score), 0);
        step("c_a", 1'b0, 2'b00, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0);
        idle_steps("c_a_hold", 3, 3'd2, 3'd2, 3'd0);
        step("c_a_back", 1'b0, 2'b10, 1'b0, 3'd1, 3'd2, 3'd0, 1'b1, 1'b1);
        step("c_b", 1'b0, 2'b00, 1'b1, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0);
        idle_steps("c_b_hold", 3, 3'd2, 3'd1, 3'd0);
        step("c_b_back", 1'b0, 2'b10, 1'b0, 3'd1, 3'd1, 3'd0, 1'b1, 1'b1);
        step("c_c", 1'b0, 2'b00, 1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0);
        step("gameover_stat", 1'b0, 2'b00, 1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0);
        step("go_start", 1'b1, 2'b10, 1'b0, 3'd1, 3'd3, 3'd0, 1'b1, 1'b1);

        step("rc_crash", 1'b0, 2'b00, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0);
        step("rc_c2", 1'b0, 2'b10, 1'b0, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_rst", z);
        check("async_rst.score", 32'(score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 2'b00, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        step("post_start", 1'b1, 2'b10, 1'b0, 3'd1, 3'd3, 3'd0, 1'b1, 1'b1);
        step("pr_crash", 1'b0, 2'b00, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0);
        idle_steps("pr_hold", 3, 3'd2, 3'd2, 3'd0);
        step("pr_back", 1'b0, 2'b10, 1'b0, 3'd1, 3'd2, 3'd0, 1'b1, 1'b1);

        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sc_game_state_ctrl.md
SC_GAME_STATE_CTRL -- requirements
Module: sc_game_state_ctrl

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, meaning the lives loaded at game start (range 1..7).
REQ-002 SHALL have parameter LEVELS, default 4, meaning the number of levels before victory (range 1..8).
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning the dwell time in CRASH and LEVEL_UP (at least 1).
REQ-004 SHALL have port SC_GAME_STATE_CTRL_CLOCK_50, input, width 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port SC_GAME_STATE_CTRL_RESET_InLow, input, width 1: asynchronous, active-low reset.
REQ-006 SHALL have port SC_GAME_STATE_CTRL_status_InBUS, input, width 2: comparator result (00 crash, 11 goal row reached, 10/01 nothing).
REQ-007 SHALL have port SC_GAME_STATE_CTRL_statusValid_In, input, width 1: strobe marking the status input as settled.
REQ-008 SHALL have port SC_GAME_STATE_CTRL_start_In, input, width 1: single-cycle start pulse, already debounced.
REQ-009 SHALL have port SC_GAME_STATE_CTRL_state_OutBUS, output, width 3: current state code.
REQ-010 SHALL have port SC_GAME_STATE_CTRL_lives_OutBUS, output, width 3: lives remaining.
REQ-011 SHALL have port SC_GAME_STATE_CTRL_level_OutBUS, output, width 3: current level, zero-based.
REQ-012 SHALL have port SC_GAME_STATE_CTRL_frogReset_Out, output, width 1: one-cycle pulse that returns the frog to the start row.
REQ-013 SHALL have port SC_GAME_STATE_CTRL_obstacleEn_Out, output, width 1: enable for the obstacle shift registers.
REQ-014 SHALL have port SC_GAME_STATE_CTRL_score_OutBUS, output, width 8: game score.

Function
REQ-015 SHALL implement states IDLE=0, PLAY=1, CRASH=2, LEVEL_UP=3, GAME_OVER=4, VICTORY=5; codes 6 and 7 SHALL recover to IDLE on the next edge.
REQ-016 SHALL sample the status input only when in PLAY and statusValid is 1; in all other cases status is ignored.
REQ-017 In IDLE, GAME_OVER or VICTORY, a start pulse SHALL set lives=LIVES_INIT, level=0 and score=0, and SHALL enter PLAY; start SHALL be ignored in PLAY, CRASH and LEVEL_UP.
REQ-018 In PLAY with a valid status of 00, the block SHALL decrement lives; if lives was 1 it SHALL go to GAME_OVER with lives=0, otherwise it SHALL go to CRASH.
REQ-019 In PLAY with a valid status of 11, the block SHALL go to VICTORY if level==LEVELS-1, otherwise to LEVEL_UP.
REQ-020 On entry to CRASH or LEVEL_UP, the block SHALL load the hold counter and stay exactly HOLD_CYCLES cycles, then return to PLAY; it SHALL increment level when leaving LEVEL_UP.
REQ-021 frogReset SHALL pulse high for exactly one cycle, in the first cycle the state output reads PLAY after any transition into PLAY.
REQ-022 obstacleEn SHALL be 1 only while the state is PLAY, including the first PLAY cycle.
REQ-023 All outputs SHALL be registered, and state/lives/level SHALL update on the edge that samples the triggering input (latency 1 cycle).
REQ-024 The hold counter SHALL be $clog2(HOLD_CYCLES+1) bits wide and SHALL never wrap; lives SHALL never underflow below 0.

Reset
REQ-025 Reset assertion SHALL asynchronously force state=IDLE, lives=0, level=0, score=0, frogReset=0, obstacleEn=0 and hold counter=0, including mid-hold or mid-game.
REQ-026 After reset release, the block SHALL remain in IDLE until a start pulse arrives.

Configuration
REQ-027 With SC_GAME_STATE_CTRL_SCORE_EN defined, each valid goal SHALL add level+1 to score, saturating at 8'hFF.
REQ-028 With SC_GAME_STATE_CTRL_SCORE_EN undefined, no score logic SHALL exist and the score port SHALL be constant 0; the port list is unchanged.

Structure
REQ-029 Package game_pkg SHALL hold the state codes, the status codes (ST_CRASH=2'b00, ST_NONE=2'b10, ST_GOAL=2'b11) and the score width.
REQ-030 The hold timing SHALL be a sub-module sc_hold_timer, with load/expire behaviour and HOLD_CYCLES as its parameter.

Verification (LIVES_INIT=3, LEVELS=2, HOLD_CYCLES=4)
REQ-031 Reset then start pulse -> state=1, lives=3, level=0, frogReset high for 1 cycle, obstacleEn=1.
REQ-032 PLAY with status=00 and valid=1 -> state=2, lives=2, obstacleEn=0 for 4 cycles, then state=1 with a frogReset pulse.
REQ-033 Goal at level 0 -> LEVEL_UP for 4 cycles, then level=1; goal at level 1 -> state=5; with SCORE_EN defined, score=3.
REQ-034 Three crashes -> lives 2, 1, then state=4 with lives=0; a later status=00 leaves lives at 0; start -> state=1, lives=3.
REQ-035 status=00 with valid=0, and start pulses during CRASH -> no state change.
REQ-036 Reset asserted in the 2nd cycle of CRASH -> immediately state=0 and all outputs 0, with no clock edge needed.
